// File: rtl/sample_streamer.sv
// sample_streamer: 256-entry sample buffer that is loaded by the Avalon load
// stage and then streamed to the FFT core with a valid/ready handshake, in
// either bit-reversed or natural order.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   wr_en      sample write strobe
//   wr_addr    sample index (0..255 valid, 256..511 rejected)
//   wr_data    sample value
//   start      single-cycle request to stream the buffer
//   out_valid  out_data holds a valid sample
//   out_ready  downstream accepts the sample
//   out_data   streamed sample
//   out_index  stream position 0..255 of out_data
//   busy       high while prefetching or streaming
//   done       one-cycle pulse after the last handshake
//   wr_drop    one-cycle pulse when a write is rejected
//   load_count writes accepted since the last start, saturating at 256
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | buffer writable, waiting for start
// PREFETCH | fetch the first sample of the stream
// STREAM   | present samples; advance on each handshake until index 255

module sample_streamer #(
    parameter int DATA_W = 16,
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [8:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_index,
    output logic              busy,
    output logic              done,
    output logic              wr_drop,
    output logic [8:0]        load_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [256];

    logic [7:0] idx_nxt;
    logic [7:0] rd_addr;
    logic       valid_nxt;
    logic       done_nxt;
    logic       load_en;
    logic       wr_accept;
    logic       wr_reject;

    function automatic logic [7:0] rd_map(input logic [7:0] idx);
        logic [7:0] r;
        r = idx;
        if (BITREV) begin
            for (int k = 0; k < 8; k++) begin
                r[k] = idx[7-k];
            end
        end
        return r;
    endfunction

    // Writes are only legal while idle; anything else (including an
    // out-of-range address while idle) is reported through wr_drop.
    assign wr_accept = wr_en && !wr_addr[8] && (state == IDLE);
    assign wr_reject = wr_en && (wr_addr[8] || (state != IDLE));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = out_index;
        valid_nxt = out_valid;
        done_nxt  = 1'b0;
        load_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PREFETCH;
                    idx_nxt   = 8'd0;
                end
            end
            PREFETCH: begin
                state_nxt = STREAM;
                idx_nxt   = 8'd0;
                valid_nxt = 1'b1;
                load_en   = 1'b1;
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_index == 8'd255) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = out_index + 8'd1;
                        load_en = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        rd_addr = rd_map(idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer has no reset so its contents survive an aborted stream. A write
    // coincident with start lands here before PREFETCH reads, so it is seen.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_addr[7:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= 8'd0;
            done       <= 1'b0;
            wr_drop    <= 1'b0;
            load_count <= 9'd0;
        end else begin
            out_valid <= valid_nxt;
            out_index <= idx_nxt;
            done      <= done_nxt;
            wr_drop   <= wr_reject;
            if (load_en) begin
                out_data <= mem[rd_addr];
            end
            // start wins over a same-cycle write so the count ends at zero.
            if ((state == IDLE) && start) begin
                load_count <= 9'd0;
            end else if (wr_accept && (load_count != 9'd256)) begin
                load_count <= load_count + 9'd1;
            end
        end
    end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter BITREV, default 1; 1 = bit-reversed read order, 0 = natural order.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, sample write strobe from the Avalon load stage.
REQ-006 SHALL have port wr_addr, input, 9, sample index; only 0..255 are valid.
REQ-007 SHALL have port wr_data, input, DATA_W, sample value.
REQ-008 SHALL have port start, input, 1, single-cycle request to stream the buffer.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a valid sample.
REQ-010 SHALL have port out_ready, input, 1, downstream FFT core accepts the sample.
REQ-011 SHALL have port out_data, output, DATA_W, streamed sample.
REQ-012 SHALL have port out_index, output, 8, stream position 0..255 of out_data.
REQ-013 SHALL have port busy, output, 1, high in PREFETCH and STREAM.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the last handshake.
REQ-015 SHALL have port wr_drop, output, 1, one-cycle pulse when a write is rejected.
REQ-016 SHALL have port load_count, output, 9, number of writes accepted since the last start, saturating at 256.

Function
REQ-017 SHALL hold a 256 x DATA_W sample buffer; contents are not cleared by reset.
REQ-018 SHALL implement states IDLE, PREFETCH and STREAM.
REQ-019 In IDLE, a write with wr_en=1 and wr_addr<256 SHALL store wr_data at wr_addr[7:0] and increment load_count, saturating at 256.
REQ-020 A write with wr_addr>=256, in any state, SHALL be dropped and pulse wr_drop in the next cycle.
REQ-021 A write with wr_en=1 in PREFETCH or STREAM SHALL be dropped and pulse wr_drop in the next cycle.
REQ-022 In IDLE, start=1 SHALL move to PREFETCH, clear the stream index to 0 and clear load_count to 0, regardless of load_count value.
REQ-023 If a write and start occur in the same IDLE cycle, the write SHALL be stored and SHALL be visible to the stream.
REQ-024 If a write and start occur in the same IDLE cycle, load_count SHALL end at 0.
REQ-025 start in PREFETCH or STREAM SHALL be ignored.
REQ-026 PREFETCH SHALL load out_data from buffer[rd(0)], set out_valid=1 and out_index=0, and move to STREAM. rd(i) = bit-reverse8(i) when BITREV=1, else i.
REQ-027 Latency: start asserted in cycle t SHALL give out_valid=1 from cycle t+2.
REQ-028 In STREAM, out_data, out_index and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 In STREAM, a handshake (out_valid and out_ready both 1) with index<255 SHALL load buffer[rd(index+1)], increment out_index and keep out_valid=1, giving one sample per cycle under continuous out_ready.
REQ-030 A handshake at index 255 SHALL clear out_valid, pulse done for one cycle and return to IDLE.
REQ-031 busy SHALL be 1 exactly in PREFETCH and STREAM.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE with out_valid=0, out_data=0, out_index=0, busy=0, done=0, wr_drop=0 and load_count=0.
REQ-033 Reset in mid-stream SHALL abort the stream with no done pulse; buffer contents SHALL persist.
REQ-034 Any write or start coincident with rst=1 SHALL be ignored.

Verification
REQ-035 SHALL cover: write buffer[i]=i for i=0..255, then start, out_ready=1 with BITREV=1 -> load_count 256 before start; 256 consecutive handshakes; out_data = bitrev(out_index); first sample 0, second 0x80; done pulses once; busy falls with done.
REQ-036 SHALL cover: BITREV=0, out_ready toggled 1,0,1,0 -> out_data[k]=k; outputs held stable during every stall; exactly 256 transfers.
REQ-037 SHALL cover: writes at wr_addr=256 and 300 in IDLE, and any write during STREAM -> wr_drop pulses; buffer and load_count unchanged.
REQ-038 SHALL cover: write (addr 0, 0xABCD) in the same cycle as start, BITREV=0 -> first streamed sample 0xABCD; load_count=0.
REQ-039 SHALL cover: rst at index 100 -> out_valid=0 next cycle, no done; restart -> full 256-sample stream with original data.
REQ-040 SHALL cover: start re-asserted during STREAM -> ignored; stream index continues to 255.
